// File: rtl/dcache_pkg.sv
// Shared types and widths for the direct-mapped write-back data cache.
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } state_e;

   localparam int LINE_W   = 256;
   localparam int OFFSET_W = 5;
   localparam int WORDS    = LINE_W / 32;
   localparam int IDX_W    = 5;
   localparam int TAG_W    = 32 - OFFSET_W - IDX_W;

   // {tag, index} -> byte address of the block, offset bits zeroed
   function automatic logic [31:0] blk_addr(input logic [31-OFFSET_W:0] line_no);
      return {line_no, {OFFSET_W{1'b0}}};
   endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty and data storage: combinational read, synchronous write.
module dcache_sram
   import dcache_pkg::*;
#(
   parameter int NUM_LINES = 32,
   parameter int IW        = 5,
   parameter int TW        = 22
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [IW-1:0]     rd_idx,
   output logic              rd_valid,
   output logic              rd_dirty,
   output logic [TW-1:0]     rd_tag,
   output logic [LINE_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [IW-1:0]     wr_idx,
   input  logic [TW-1:0]     wr_tag,
   input  logic              wr_valid,
   input  logic              wr_dirty,
   input  logic [LINE_W-1:0] wr_data,
   input  logic [WORDS-1:0]  wr_word_en
);

   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] dirty_q;
   logic [TW-1:0]        tag_q  [NUM_LINES];
   logic [LINE_W-1:0]    data_q [NUM_LINES];

   assign rd_valid = valid_q[rd_idx];
   assign rd_dirty = dirty_q[rd_idx];
   assign rd_tag   = tag_q[rd_idx];
   assign rd_data  = data_q[rd_idx];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= wr_valid;
         dirty_q[wr_idx] <= wr_dirty;
      end
   end

   // Storage arrays carry no reset; valid bits gate every use of them
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         tag_q[wr_idx] <= wr_tag;
         for (int w = 0; w < WORDS; w++) begin
            if (wr_word_en[w]) data_q[wr_idx][32*w +: 32] <= wr_data[32*w +: 32];
         end
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate L1 D-cache controller with miss FSM and memory watchdog.
//   state     | meaning
//   IDLE      | serving hits; a miss picks write-back or refill
//   WRITEBACK | dirty victim block being written to memory
//   ALLOCATE  | refill of the requested block from memory
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int NUM_LINES   = 32,
   parameter int MEM_LAT_MAX = 1023
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [31:0]       p1_addr_i,
   input  logic [31:0]       p1_data_i,
   input  logic              p1_MemRead_i,
   input  logic              p1_MemWrite_i,
   output logic [31:0]       p1_data_o,
   output logic              p1_stall_o,
   output logic [31:0]       mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i,
   output logic              mem_err_o
);

   localparam int IW   = $clog2(NUM_LINES);
   localparam int TW   = 32 - OFFSET_W - IW;
   localparam int WD_W = $clog2(MEM_LAT_MAX + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(MEM_LAT_MAX);

   state_e            state_q;
   logic [WD_W-1:0]   wd_q;

   logic [2:0]        word_off;
   logic [IW-1:0]     idx;
   logic [TW-1:0]     tag;
   logic              req;
   logic              hit;
   logic              unused_addr;

   logic              line_valid;
   logic              line_dirty;
   logic [TW-1:0]     line_tag;
   logic [LINE_W-1:0] line_data;

   logic              sram_we;
   logic              sram_dirty;
   logic [LINE_W-1:0] sram_wdata;
   logic [WORDS-1:0]  sram_word_en;

   assign word_off    = p1_addr_i[4:2];
   assign idx         = p1_addr_i[OFFSET_W +: IW];
   assign tag         = p1_addr_i[31 -: TW];
   assign unused_addr = ^p1_addr_i[1:0];

   assign req        = p1_MemRead_i | p1_MemWrite_i;
   assign hit        = req & line_valid & (line_tag == tag);
   assign p1_stall_o = req & (~hit | (state_q != IDLE));
   assign p1_data_o  = hit ? line_data[{word_off, 5'b0} +: 32] : 32'h0;

   dcache_sram #(
      .NUM_LINES (NUM_LINES),
      .IW        (IW),
      .TW        (TW)
   ) u_sram (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .rd_idx     (idx),
      .rd_valid   (line_valid),
      .rd_dirty   (line_dirty),
      .rd_tag     (line_tag),
      .rd_data    (line_data),
      .wr_en      (sram_we),
      .wr_idx     (idx),
      .wr_tag     (tag),
      .wr_valid   (1'b1),
      .wr_dirty   (sram_dirty),
      .wr_data    (sram_wdata),
      .wr_word_en (sram_word_en)
   );

   // Refill writes the whole line clean; a store hit merges one word and marks it dirty
   always_comb begin
      sram_we      = 1'b0;
      sram_dirty   = 1'b1;
      sram_wdata   = {WORDS{p1_data_i}};
      sram_word_en = '0;
      if (state_q == ALLOCATE && mem_ack_i) begin
         sram_we      = 1'b1;
         sram_dirty   = 1'b0;
         sram_wdata   = mem_data_i;
         sram_word_en = '1;
      end else if (state_q == IDLE && hit && p1_MemWrite_i) begin
         sram_we      = 1'b1;
         sram_word_en = WORDS'(1) << word_off;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= IDLE;
         mem_enable_o <= 1'b0;
         mem_write_o  <= 1'b0;
         mem_addr_o   <= '0;
         mem_data_o   <= '0;
         mem_err_o    <= 1'b0;
         wd_q         <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req && !hit) begin
                  wd_q         <= '0;
                  mem_enable_o <= 1'b1;
                  if (line_valid && line_dirty) begin
                     state_q     <= WRITEBACK;
                     mem_write_o <= 1'b1;
                     mem_addr_o  <= blk_addr({line_tag, idx});
                     mem_data_o  <= line_data;
                  end else begin
                     state_q     <= ALLOCATE;
                     mem_write_o <= 1'b0;
                     mem_addr_o  <= blk_addr({tag, idx});
                  end
               end
            end
            WRITEBACK: begin
               if (mem_ack_i) begin
                  state_q     <= ALLOCATE;
                  wd_q        <= '0;
                  mem_write_o <= 1'b0;
                  mem_addr_o  <= blk_addr({tag, idx});
               end else begin
                  if (wd_q != WD_MAX) wd_q <= wd_q + 1'b1;
                  if (wd_q == WD_MAX - 1'b1) mem_err_o <= 1'b1;
               end
            end
            ALLOCATE: begin
               if (mem_ack_i) begin
                  state_q      <= IDLE;
                  mem_enable_o <= 1'b0;
               end else begin
                  if (wd_q != WD_MAX) wd_q <= wd_q + 1'b1;
                  if (wd_q == WD_MAX - 1'b1) mem_err_o <= 1'b1;
               end
            end
            default: begin
               state_q      <= IDLE;
               mem_enable_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed plus randomized bench for dcache_ctrl against a line-level cache/memory model.
module tb_dcache_ctrl;

   localparam int NL = 32;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b0;
   logic [31:0]  p1_addr_i = '0;
   logic [31:0]  p1_data_i = '0;
   logic         p1_MemRead_i = 1'b0;
   logic         p1_MemWrite_i = 1'b0;
   logic [31:0]  p1_data_o;
   logic         p1_stall_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic         mem_enable_o;
   logic         mem_write_o;
   logic [255:0] mem_data_i = '0;
   logic         mem_ack_i = 1'b0;
   logic         mem_err_o;

   dcache_ctrl #(.NUM_LINES(NL), .MEM_LAT_MAX(20)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .p1_addr_i     (p1_addr_i),
      .p1_data_i     (p1_data_i),
      .p1_MemRead_i  (p1_MemRead_i),
      .p1_MemWrite_i (p1_MemWrite_i),
      .p1_data_o     (p1_data_o),
      .p1_stall_o    (p1_stall_o),
      .mem_addr_o    (mem_addr_o),
      .mem_data_o    (mem_data_o),
      .mem_enable_o  (mem_enable_o),
      .mem_write_o   (mem_write_o),
      .mem_data_i    (mem_data_i),
      .mem_ack_i     (mem_ack_i),
      .mem_err_o     (mem_err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic         wr;
      logic [31:0]  addr;
      logic [255:0] data;
   } txn_t;

   int checks = 0;
   int failures = 0;

   // reference model: backing memory by block address plus per-line cache contents
   logic [255:0] mem [logic [31:0]];
   bit           m_valid [NL];
   bit           m_dirty [NL];
   int unsigned  m_tag   [NL];
   logic [255:0] m_line  [NL];
   txn_t         exp_q [$];
   txn_t         got_q [$];

   task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   function automatic logic [255:0] mem_rd(input logic [31:0] blk);
      logic [255:0] v;
      if (!mem.exists(blk)) begin
         for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
         mem[blk] = v;
      end
      return mem[blk];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NL; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
   endtask

   task automatic model_access(input logic [31:0] a, input bit wr, input logic [31:0] wd, input int dly,
                               output int exp_stall, output logic [31:0] exp_rd);
      int unsigned li = (a / 32) % NL;
      int unsigned tg = a / (32 * NL);
      int unsigned w  = (a / 4) % 8;
      logic [31:0] blk = a & ~32'd31;
      logic [31:0] va;
      exp_q.delete();
      exp_stall = 0;
      if (!(m_valid[li] && m_tag[li] == tg)) begin
         exp_stall = dly + 2;
         if (m_valid[li] && m_dirty[li]) begin
            va = m_tag[li] * 32 * NL + li * 32;
            mem[va] = m_line[li];
            exp_q.push_back('{1'b1, va, m_line[li]});
            exp_stall += dly + 1;
         end
         exp_q.push_back('{1'b0, blk, 256'h0});
         m_line[li]  = mem_rd(blk);
         m_valid[li] = 1'b1;
         m_dirty[li] = 1'b0;
         m_tag[li]   = tg;
      end
      exp_rd = m_line[li][w*32 +: 32];
      if (wr) begin
         m_line[li][w*32 +: 32] = wd;
         m_dirty[li] = 1'b1;
      end
   endtask

   // Entered just after a rising edge; memory acks in the (dly+1)-th enable cycle of each transfer
   task automatic dut_access(input logic [31:0] a, input bit rd, input bit wr, input logic [31:0] wd,
                             input int dly, output int st, output logic [31:0] rdv, output bit en_done);
      int en_cnt = 0;
      bit done = 1'b0;
      got_q.delete();
      st = 0;
      rdv = '0;
      en_done = 1'b0;
      p1_addr_i = a;
      p1_data_i = wd;
      p1_MemRead_i = rd;
      p1_MemWrite_i = wr;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk_i);
         mem_ack_i = 1'b0;
         if (!p1_stall_o) begin
            rdv = p1_data_o;
            en_done = mem_enable_o;
            done = 1'b1;
            break;
         end
         st++;
         if (mem_enable_o) begin
            if (en_cnt == 0) got_q.push_back('{mem_write_o, mem_addr_o, mem_data_o});
            en_cnt++;
            if (en_cnt == dly + 1) begin
               mem_ack_i = 1'b1;
               if (!mem_write_o) mem_data_i = mem_rd(mem_addr_o);
               en_cnt = 0;
            end
         end
      end
      mem_ack_i = 1'b0;
      chk("access_timeout", 256'(done), 256'(1));
      @(posedge clk_i);
      #1;
      p1_MemRead_i = 1'b0;
      p1_MemWrite_i = 1'b0;
   endtask

   task automatic run(input logic [31:0] a, input bit rd, input bit wr, input logic [31:0] wd, input int dly);
      int exp_stall;
      int st;
      logic [31:0] exp_rd;
      logic [31:0] rdv;
      bit en_done;
      model_access(a, wr, wd, dly, exp_stall, exp_rd);
      dut_access(a, rd, wr, wd, dly, st, rdv, en_done);
      chk("stall_cycles", 256'(st), 256'(exp_stall));
      chk("enable_after_done", 256'(en_done), 256'(0));
      chk("txn_count", 256'(got_q.size()), 256'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         chk("txn_write", 256'(got_q[i].wr), 256'(exp_q[i].wr));
         chk("txn_addr", 256'(got_q[i].addr), 256'(exp_q[i].addr));
         if (exp_q[i].wr) chk("txn_wb_data", got_q[i].data, exp_q[i].data);
      end
      if (!wr) chk("read_data", 256'(rdv), 256'(exp_rd));
   endtask

   task automatic do_reset();
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      model_reset();
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      logic [31:0] a;
      bit wr;
      int en;
      model_reset();

      // reset state
      repeat (2) @(negedge clk_i);
      chk("rst_enable", 256'(mem_enable_o), 256'(0));
      chk("rst_write", 256'(mem_write_o), 256'(0));
      chk("rst_addr", 256'(mem_addr_o), 256'(0));
      chk("rst_data", mem_data_o, 256'h0);
      chk("rst_err", 256'(mem_err_o), 256'(0));
      chk("rst_stall", 256'(p1_stall_o), 256'(0));
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;

      // cold miss, hit, store hit, dirty eviction, clean store miss
      run(32'h0000_0400, 1'b1, 1'b0, 32'h0, 10);
      run(32'h0000_0404, 1'b1, 1'b0, 32'h0, 3);
      run(32'h0000_0408, 1'b0, 1'b1, 32'hDEAD_BEEF, 3);
      run(32'h0000_0808, 1'b1, 1'b0, 32'h0, 2);
      if (got_q.size() > 0) chk("wb_word2", 256'(got_q[0].data[95:64]), 256'(32'hDEAD_BEEF));
      run(32'h0000_0C0C, 1'b0, 1'b1, 32'h1234_5678, 4);
      run(32'h0000_0C0C, 1'b1, 1'b0, 32'h0, 4);

      // ack while idle must be ignored
      @(negedge clk_i);
      mem_ack_i = 1'b1;
      mem_data_i = {8{$urandom}};
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      chk("idle_ack_enable", 256'(mem_enable_o), 256'(0));
      @(posedge clk_i);
      #1;

      for (int n = 0; n < 60; n++) begin
         a = (($urandom % 4 + 1) << 10) | (($urandom % 4) << 5) | (($urandom % 8) << 2) | ($urandom % 4);
         wr = $urandom_range(0, 1) == 1;
         run(a, wr ? bit'($urandom_range(0, 1)) : 1'b1, wr, $urandom, $urandom_range(0, 6));
      end

      // reset in the middle of a refill drops the dirty line without a write-back
      do_reset();
      run(32'h0000_1024, 1'b0, 1'b1, 32'hCAFE_F00D, 1);
      p1_addr_i = 32'h0000_3000;
      p1_MemRead_i = 1'b1;
      en = 0;
      for (int c = 0; c < 50 && en < 3; c++) begin
         @(negedge clk_i);
         if (mem_enable_o) en++;
      end
      chk("alloc_reached", 256'(en), 256'(3));
      #1;
      rst_i = 1'b0;
      model_reset();
      #1;
      chk("midrst_enable", 256'(mem_enable_o), 256'(0));
      chk("midrst_addr", 256'(mem_addr_o), 256'(0));
      @(negedge clk_i);
      rst_i = 1'b1;
      p1_MemRead_i = 1'b0;
      @(posedge clk_i);
      #1;
      run(32'h0000_1024, 1'b1, 1'b0, 32'h0, 2);
      run(32'h0000_3000, 1'b1, 1'b0, 32'h0, 2);

      // watchdog: never ack
      p1_addr_i = 32'h0000_5040;
      p1_MemRead_i = 1'b1;
      en = 0;
      for (int c = 0; c < 100 && en < 21; c++) begin
         @(negedge clk_i);
         if (mem_enable_o) en++;
         if (en == 20) chk("wd_err_early", 256'(mem_err_o), 256'(0));
         if (en == 21) chk("wd_err_set", 256'(mem_err_o), 256'(1));
      end
      chk("wd_reached", 256'(en), 256'(21));
      repeat (5) @(negedge clk_i);
      chk("wd_err_sticky", 256'(mem_err_o), 256'(1));
      chk("wd_stall_held", 256'(p1_stall_o), 256'(1));
      chk("wd_enable_held", 256'(mem_enable_o), 256'(1));
      p1_MemRead_i = 1'b0;
      do_reset();
      @(negedge clk_i);
      chk("wd_err_cleared", 256'(mem_err_o), 256'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
